// File: rtl/list_walker_if.sv
// Bundle of the list walker's control, memory-read and element-stream signals.
// master = walker side, slave = evaluator/memory/consumer side.
interface list_walker_if;
    logic        start;
    logic [15:0] list_ptr;
    logic        busy;
    logic        mem_read_enable;
    logic [15:0] mem_addr;
    logic [14:0] mem_header;
    logic [15:0] mem_car;
    logic [15:0] mem_cdr;
    logic        mem_done;
    logic        elem_valid;
    logic        elem_ready;
    logic [15:0] elem_data;
    logic        elem_last;
    logic        done;
    logic [7:0]  count;
    logic [1:0]  err_code;

    modport master (
        input  start, list_ptr, mem_header, mem_car, mem_cdr, mem_done, elem_ready,
        output busy, mem_read_enable, mem_addr, elem_valid, elem_data, elem_last,
               done, count, err_code
    );

    modport slave (
        output start, list_ptr, mem_header, mem_car, mem_cdr, mem_done, elem_ready,
        input  busy, mem_read_enable, mem_addr, elem_valid, elem_data, elem_last,
               done, count, err_code
    );
endinterface

// File: rtl/list_walker.sv
// list_walker: walks a proper Lisp list in cell memory and streams each car over valid/ready.
// Optional macro WALKER_PREFETCH_EN overlaps the next cell read with the current element.
module list_walker #(
    parameter int unsigned MaxLen   = 64,
    parameter logic [15:0] LispNil  = 16'h0000,
    parameter logic [14:0] TypeCons = 15'h0001
) (
    input logic           clk,
    input logic           rst,
    list_walker_if.master bus
);
    localparam int unsigned AddrW = 16;
    localparam int unsigned CntW  = 8;
    localparam logic [1:0]  ErrOk       = 2'b00;
    localparam logic [1:0]  ErrHead     = 2'b01;
    localparam logic [1:0]  ErrImproper = 2'b10;
    localparam logic [1:0]  ErrTooLong  = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EMIT, S_FIN} state_t;

    state_t           r_state, w_state_nx;
    logic [AddrW-1:0] r_mem_addr, w_mem_addr_nx;
    logic [AddrW-1:0] r_elem_data, w_elem_data_nx;
    logic             r_elem_last, w_elem_last_nx;
    logic [CntW-1:0]  r_count, w_count_nx;
    logic [1:0]       r_err, w_err_nx;
    logic             r_mem_re, r_busy, r_elem_valid, r_done;
    logic             w_issue, w_hs, w_cell_cons, w_cdr_nil;
    logic [CntW-1:0]  w_cnt_inc;
`ifdef WALKER_PREFETCH_EN
    // One-entry holding register for the cell read ahead during EMIT
    logic             r_pf_pend, w_pf_pend_nx;
    logic             r_pf_full, w_pf_full_nx;
    logic [AddrW-1:0] r_pf_car, w_pf_car_nx;
    logic [AddrW-1:0] r_pf_cdr, w_pf_cdr_nx;
    logic             r_pf_cons, w_pf_cons_nx;
    logic             r_drain, w_drain_nx;
`else
    logic [AddrW-1:0] r_cdr, w_cdr_nx;
`endif

    always_comb begin
        w_state_nx     = r_state;
        w_mem_addr_nx  = r_mem_addr;
        w_elem_data_nx = r_elem_data;
        w_elem_last_nx = r_elem_last;
        w_count_nx     = r_count;
        w_err_nx       = r_err;
        w_issue        = 1'b0;
        w_hs           = r_elem_valid & bus.elem_ready;
        w_cnt_inc      = r_count + CntW'(1);
        w_cell_cons    = (bus.mem_header == TypeCons);
        w_cdr_nil      = (bus.mem_cdr == LispNil);
`ifdef WALKER_PREFETCH_EN
        w_pf_pend_nx   = r_pf_pend;
        w_pf_full_nx   = r_pf_full;
        w_pf_car_nx    = r_pf_car;
        w_pf_cdr_nx    = r_pf_cdr;
        w_pf_cons_nx   = r_pf_cons;
        w_drain_nx     = r_drain;
`else
        w_cdr_nx       = r_cdr;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_count_nx = '0;
                    w_err_nx   = ErrOk;
                    if (bus.list_ptr == LispNil) begin
                        w_state_nx = S_FIN;
                    end else begin
                        w_mem_addr_nx = bus.list_ptr;
                        w_state_nx    = S_REQ;
                    end
                end
            end
            S_REQ: w_state_nx = S_WAIT;
            S_WAIT: begin
                if (bus.mem_done) begin
`ifdef WALKER_PREFETCH_EN
                    if (r_drain) begin
                        w_drain_nx = 1'b0;
                        w_state_nx = S_FIN;
                    end else
`endif
                    if (!w_cell_cons) begin
                        w_err_nx   = (r_count == '0) ? ErrHead : ErrImproper;
                        w_state_nx = S_FIN;
                    end else begin
                        w_elem_data_nx = bus.mem_car;
                        w_elem_last_nx = w_cdr_nil;
                        w_state_nx     = S_EMIT;
`ifdef WALKER_PREFETCH_EN
                        if (!w_cdr_nil) begin
                            w_issue       = 1'b1;
                            w_mem_addr_nx = bus.mem_cdr;
                            w_pf_pend_nx  = 1'b1;
                        end
`else
                        w_cdr_nx       = bus.mem_cdr;
`endif
                    end
                end
            end
            S_EMIT: begin
`ifdef WALKER_PREFETCH_EN
                if (r_pf_pend && bus.mem_done) begin
                    w_pf_pend_nx = 1'b0;
                    w_pf_full_nx = 1'b1;
                    w_pf_car_nx  = bus.mem_car;
                    w_pf_cdr_nx  = bus.mem_cdr;
                    w_pf_cons_nx = w_cell_cons;
                end
`endif
                if (w_hs) begin
                    w_count_nx = w_cnt_inc;
                    if (r_elem_last) begin
                        w_state_nx = S_FIN;
                    end else if (w_cnt_inc == CntW'(MaxLen)) begin
                        w_err_nx   = ErrTooLong;
                        w_state_nx = S_FIN;
`ifdef WALKER_PREFETCH_EN
                        // Discard the read-ahead cell, but let an in-flight read finish first
                        w_pf_full_nx = 1'b0;
                        if (r_pf_pend && !bus.mem_done) begin
                            w_pf_pend_nx = 1'b0;
                            w_drain_nx   = 1'b1;
                            w_state_nx   = S_WAIT;
                        end
`endif
                    end else begin
`ifdef WALKER_PREFETCH_EN
                        if (w_pf_full_nx) begin
                            w_pf_full_nx = 1'b0;
                            if (!w_pf_cons_nx) begin
                                w_err_nx   = ErrImproper;
                                w_state_nx = S_FIN;
                            end else begin
                                w_elem_data_nx = w_pf_car_nx;
                                w_elem_last_nx = (w_pf_cdr_nx == LispNil);
                                if (w_pf_cdr_nx != LispNil) begin
                                    w_issue       = 1'b1;
                                    w_mem_addr_nx = w_pf_cdr_nx;
                                    w_pf_pend_nx  = 1'b1;
                                end
                            end
                        end else begin
                            w_pf_pend_nx = 1'b0;
                            w_state_nx   = S_WAIT;
                        end
`else
                        w_mem_addr_nx = r_cdr;
                        w_state_nx    = S_REQ;
`endif
                    end
                end
            end
            S_FIN:   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_mem_addr   <= '0;
            r_elem_data  <= '0;
            r_elem_last  <= 1'b0;
            r_count      <= '0;
            r_err        <= ErrOk;
            r_mem_re     <= 1'b0;
            r_busy       <= 1'b0;
            r_elem_valid <= 1'b0;
            r_done       <= 1'b0;
`ifdef WALKER_PREFETCH_EN
            r_pf_pend    <= 1'b0;
            r_pf_full    <= 1'b0;
            r_pf_car     <= '0;
            r_pf_cdr     <= '0;
            r_pf_cons    <= 1'b0;
            r_drain      <= 1'b0;
`else
            r_cdr        <= '0;
`endif
        end else begin
            r_state      <= w_state_nx;
            r_mem_addr   <= w_mem_addr_nx;
            r_elem_data  <= w_elem_data_nx;
            r_elem_last  <= w_elem_last_nx;
            r_count      <= w_count_nx;
            r_err        <= w_err_nx;
            r_mem_re     <= (w_state_nx == S_REQ) | w_issue;
            r_busy       <= (w_state_nx != S_IDLE);
            r_elem_valid <= (w_state_nx == S_EMIT);
            r_done       <= (w_state_nx == S_FIN);
`ifdef WALKER_PREFETCH_EN
            r_pf_pend    <= w_pf_pend_nx;
            r_pf_full    <= w_pf_full_nx;
            r_pf_car     <= w_pf_car_nx;
            r_pf_cdr     <= w_pf_cdr_nx;
            r_pf_cons    <= w_pf_cons_nx;
            r_drain      <= w_drain_nx;
`else
            r_cdr        <= w_cdr_nx;
`endif
        end
    end

    assign bus.busy            = r_busy;
    assign bus.mem_read_enable = r_mem_re;
    assign bus.mem_addr        = r_mem_addr;
    assign bus.elem_valid      = r_elem_valid;
    assign bus.elem_data       = r_elem_data;
    assign bus.elem_last       = r_elem_last;
    assign bus.done            = r_done;
    assign bus.count           = r_count;
    assign bus.err_code        = r_err;
endmodule
